oh_fifo_wr_arbiter: RTL and testbench
=====================================

Name: oh_fifo_wr_arbiter

Overview:
- Shares the write port of one oh_fifo_generic between N packet-oriented requesters in the FIFO write-clock domain.
- Arbitration is round-robin, one packet at a time. The grant is held from the first beat to the beat marked last, so packets never interleave in the FIFO.
- Beats are gated by FIFO full. A new packet starts only while prog_full is low.

Parameters:
- N, 4, number of requesters (2..16).
- DW, 104, data width; must match the FIFO DW.
- NW, $clog2(N), width of the grant index.

Ports:
- clk  in  1  clock, tied to the FIFO wr_clk.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  N  per-requester beat valid.
- req_last  in  N  per-requester last-beat-of-packet flag, qualified by req_valid.
- req_data  in  N*DW  per-requester beat data; requester i occupies [i*DW+:DW].
- req_ready  out  N  per-requester beat accept.
- fifo_full  in  1  FIFO full.
- fifo_prog_full  in  1  FIFO programmable-full.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DW  FIFO write data.
- grant  out  N  one-hot registered grant; all zero when idle.
- grant_id  out  NW  binary index of the current grant.
- busy  out  1  high while in XFER.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous active-high, both assert and release. The reset release edge is already synchronized by the parent.
- Reset values:
  - state = IDLE.
  - grant = 0, grant_id = 0, busy = 0.
  - Round-robin pointer last_id = N-1, so requester 0 has top priority after reset.
  - req_ready = 0, fifo_wr_en = 0, fifo_din = 0.
- FSM state IDLE:
  - If |req_valid and ~fifo_prog_full, select the winner w: first i with req_valid[i], searching from last_id+1 upward modulo N.
  - Register grant = 1<<w and grant_id = w, then go to XFER.
  - No beat is accepted in IDLE, which gives a one-cycle arbitration bubble per packet.
- FSM state XFER:
  - Write path is combinational from the granted requester (zero-latency):
    - req_ready[i] = grant[i] & ~fifo_full.
    - fifo_wr_en = req_valid[grant_id] & req_ready[grant_id].
    - fifo_din = req_data[grant_id].
  - When fifo_din is not being written it is a don't-care; it is driven by the mux.
  - A beat transfers when valid & ready.
  - On a transfer with req_last[grant_id] = 1: last_id <= grant_id, grant <= 0, go to IDLE.
- Boundary conditions:
  - fifo_full high mid-packet: ready drops and no write occurs; the grant is held. Beats resume on the cycle full drops.
  - fifo_prog_full only blocks packet start. It is ignored once the packet is in XFER.
  - Granted requester deasserts valid mid-packet: the grant is held indefinitely and other requesters wait. There is no timeout.
  - Single-beat packet (valid & last on the first beat): IDLE -> XFER -> IDLE, one write.
  - Non-granted requesters always see req_ready = 0. Their valid/data are ignored and must be held by the requester (valid/ready protocol: valid must not drop before ready).
  - Simultaneous requests: resolved strictly round-robin. A requester that just finished has lowest priority next.
  - Reset mid-packet: the FSM aborts immediately and the partial packet stays in the FIFO. The FIFO owner handles it because both blocks share the reset.
- Throughput: the peak is L beats per L+1 cycles for an L-beat packet.

Optional Feature:
- Macro: OH_FIFO_ARB_FIXEDPRIO_EN.
- Defined: fixed priority; the lowest index with req_valid wins in IDLE. last_id is neither kept nor updated, and grant_id behaves the same.
- Undefined (default): round-robin as above.
- Ports and all other timing are identical in both builds.

Decomposition:
- Shared package/include oh_fifo_arb_defs.vh holds:
  - State localparams: IDLE = 1'b0, XFER = 1'b1.
  - The N range check macro.
- Sub-module oh_fifo_arb_rr:
  - Combinational picker, input req[N] and last_id; output one-hot gnt plus index.
  - Holds the OH_FIFO_ARB_FIXEDPRIO_EN switch.
- The top level holds the FSM, grant registers and data mux.

Test Plan (N=4, DW=8):
- Reset, then req_valid=4'b1111 with all 1-beat packets and prog_full=0 -> grant order 0,1,2,3,0; one write every 2 cycles; fifo_din = 8'h10,8'h20,8'h30,8'h40.
- Req1 sends a 3-beat packet (AA,BB,CC) while req2 is valid throughout -> FIFO receives AA,BB,CC contiguously, then req2's beat; grant_id 1 held for 3 beats.
- fifo_full=1 for cycles 2-4 of a 4-beat packet -> fifo_wr_en=0 and req_ready=0 for those cycles, grant held; all 4 beats written, order preserved.
- fifo_prog_full=1 with req0 valid in IDLE -> no grant for 10 cycles; prog_full drops -> grant=4'b0001 on the next edge.
- Reset asserted mid-packet after beat 2 of 5 -> grant, busy and fifo_wr_en go to 0 asynchronously; after release, req3 and req0 both valid -> req0 granted first.
- Build with OH_FIFO_ARB_FIXEDPRIO_EN, req0 and req2 continuously valid with 1-beat packets -> req0 wins every arbitration and req2 is never granted.

Source files
------------

// File: rtl/oh_fifo_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// oh_fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter:
//   - state_e   : arbiter FSM states (IDLE = 1'b0, XFER = 1'b1)
//   - N_MIN/N_MAX and n_in_range() : legal range of the requester count
// ----------------------------------------------------------------------------
package oh_fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  function automatic bit n_in_range(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/oh_fifo_wr_arbiter_rr.sv
// ----------------------------------------------------------------------------
// oh_fifo_wr_arbiter_rr
//   Combinational winner picker for the FIFO write arbiter.
//   Default build: round-robin, searching upward from last_id+1 modulo N.
//   With OH_FIFO_ARB_FIXEDPRIO_EN defined: fixed priority, lowest index wins,
//   last_id is ignored.
//
// Ports:
//   req     in  N   request vector
//   last_id in  NW  index of the most recently served requester
//   gnt     out N   one-hot winner (zero when req is zero)
//   gnt_id  out NW  binary index of the winner
// ----------------------------------------------------------------------------
module oh_fifo_wr_arbiter_rr #(
  parameter int N  = 4,
  parameter int NW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] last_id,
  output logic [N-1:0]  gnt,
  output logic [NW-1:0] gnt_id
);

`ifdef OH_FIFO_ARB_FIXEDPRIO_EN

  logic unused_last_id;
  assign unused_last_id = ^last_id;

  // Scan from the lowest priority upward so the final hit is the winner.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    gnt    = '0;
    gnt_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        gnt_id = NW'(i);
      end
    end
  end

`else

  // Offset k = 1 is the highest priority (the requester after last_id), k = N
  // the lowest (last_id itself). Scanning k downward leaves the winner last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_id) + k) % N]) begin
        gnt                               = '0;
        gnt[(int'(last_id) + k) % N]      = 1'b1;
        gnt_id                            = NW'((int'(last_id) + k) % N);
      end
    end
  end

`endif

endmodule

// File: rtl/oh_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// oh_fifo_wr_arbiter
//   Shares the write port of one oh_fifo_generic between N packet-oriented
//   requesters. One packet at a time: the grant is taken in IDLE (only while
//   fifo_prog_full is low) and held in XFER until the beat flagged last is
//   written, so packets never interleave. Beats are gated by fifo_full.
//   Optional macro OH_FIFO_ARB_FIXEDPRIO_EN selects fixed priority instead of
//   round-robin; ports and timing are identical in both builds.
//
// Ports:
//   clk            in  1     clock (FIFO wr_clk)
//   reset          in  1     asynchronous active-high reset
//   req_valid      in  N     per-requester beat valid
//   req_last       in  N     per-requester last beat flag
//   req_data       in  N*DW  per-requester data, requester i at [i*DW+:DW]
//   req_ready      out N     per-requester beat accept
//   fifo_full      in  1     FIFO full
//   fifo_prog_full in  1     FIFO programmable full
//   fifo_wr_en     out 1     FIFO write enable
//   fifo_din       out DW    FIFO write data
//   grant          out N     registered one-hot grant, zero when idle
//   grant_id       out NW    binary index of the current grant
//   busy           out 1     high while in XFER
// ----------------------------------------------------------------------------
module oh_fifo_wr_arbiter
  import oh_fifo_wr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 104,
  parameter int NW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  input  logic            fifo_prog_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_din,
  output logic [N-1:0]    grant,
  output logic [NW-1:0]   grant_id,
  output logic            busy
);

  if (!n_in_range(N)) begin : g_bad_n
    $error("oh_fifo_wr_arbiter: N must be in 2..16");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  grant_d;
  logic [NW-1:0] grant_id_d;
  logic [NW-1:0] last_id_q;
  logic [N-1:0]  pick_gnt;
  logic [NW-1:0] pick_id;
  logic          xfer_last;

  oh_fifo_wr_arbiter_rr #(
    .N  (N),
    .NW (NW)
  ) u_rr (
    .req     (req_valid),
    .last_id (last_id_q),
    .gnt     (pick_gnt),
    .gnt_id  (pick_id)
  );

  // Zero-latency write path from the granted requester. grant is all zero
  // outside XFER, so nobody sees ready while arbitrating.
  assign busy       = (state_q == XFER);
  assign req_ready  = grant & {N{~fifo_full}};
  assign fifo_wr_en = busy & req_valid[grant_id] & req_ready[grant_id];
  assign fifo_din   = busy ? req_data[int'(grant_id)*DW +: DW] : '0;
  assign xfer_last  = fifo_wr_en & req_last[grant_id];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    grant_id_d = grant_id;
    unique case (state_q)
      IDLE: begin
        if (|req_valid && !fifo_prog_full) begin
          grant_d    = pick_gnt;
          grant_id_d = pick_id;
          state_d    = XFER;
        end
      end
      XFER: begin
        // prog_full is deliberately ignored here: it only gates packet start.
        if (xfer_last) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
    end
  end

`ifdef OH_FIFO_ARB_FIXEDPRIO_EN
  // Fixed priority keeps no history; the picker ignores this value.
  assign last_id_q = NW'(N - 1);
`else
  // Reset to N-1 so requester 0 has top priority after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_id_q <= NW'(N - 1);
    end else if (xfer_last) begin
      last_id_q <= grant_id;
    end
  end
`endif

endmodule

// File: tb/tb_oh_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_oh_fifo_wr_arbiter
//   Scoreboard bench for oh_fifo_wr_arbiter (N=4, DW=8). Stimulus pushes
//   beats into per-requester queues and the expected FIFO writes into a
//   scoreboard; a negedge monitor pops and compares every FIFO write.
// ----------------------------------------------------------------------------
module tb_oh_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NW = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_prog_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [N-1:0]    grant;
  logic [NW-1:0]   grant_id;
  logic            busy;

  oh_fifo_wr_arbiter #(
    .N  (N),
    .DW (DW),
    .NW (NW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .grant          (grant),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    wr_count = 0;
  int    wr_log[$];
  exp_t  sb[$];
  beat_t rq[4][$];
  logic [N-1:0] acc_n = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    beat_t b;
    b.d    = d;
    b.last = last;
    rq[i].push_back(b);
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic [1:0] id);
    exp_t e;
    e.d  = d;
    e.id = id;
    sb.push_back(e);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_writes", (wr_count >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Handshake sampled mid-cycle, applied by the driver after the next edge.
  always @(negedge clk) acc_n = req_valid & req_ready;

  // Requester driver: presents the head of each queue, pops on acceptance.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      for (int i = 0; i < N; i++) begin
        if (reset) rq[i].delete();
        else if (acc_n[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i]          = (rq[i].size() > 0);
        req_last[i]           = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
        req_data[i*DW +: DW]  = (rq[i].size() > 0) ? rq[i][0].d : 8'h00;
      end
    end
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && fifo_wr_en) begin
      wr_count++;
      wr_log.push_back(cyc);
      check("wr_busy", {31'd0, busy}, 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_write", {24'd0, fifo_din}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("fifo_din", {24'd0, fifo_din}, {24'd0, e.d});
        check("grant_id", {30'd0, grant_id}, {30'd0, e.id});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    reset          = 1'b1;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant",    {28'd0, grant},     32'd0);
    check("rst_grant_id", {30'd0, grant_id},  32'd0);
    check("rst_busy",     {31'd0, busy},      32'd0);
    check("rst_ready",    {28'd0, req_ready}, 32'd0);
    check("rst_wr_en",    {31'd0, fifo_wr_en}, 32'd0);
    check("rst_din",      {24'd0, fifo_din},  32'd0);
    reset = 1'b0;

    // 1) All four requesters, single-beat packets; req0 has a second one.
    @(negedge clk);
    wr_log.delete();
    base = wr_count;
    push(0, 8'h10, 1'b1); push(0, 8'h50, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
`ifdef OH_FIFO_ARB_FIXEDPRIO_EN
    expect_wr(8'h10, 2'd0); expect_wr(8'h50, 2'd0); expect_wr(8'h20, 2'd1);
    expect_wr(8'h30, 2'd2); expect_wr(8'h40, 2'd3);
`else
    expect_wr(8'h10, 2'd0); expect_wr(8'h20, 2'd1); expect_wr(8'h30, 2'd2);
    expect_wr(8'h40, 2'd3); expect_wr(8'h50, 2'd0);
`endif
    wait_writes(base + 5, 40);
    for (int k = 0; k + 1 < wr_log.size(); k++)
      check("rr_interval", wr_log[k+1] - wr_log[k], 32'd2);

    // 2) 3-beat packet from req1 with req2 waiting: contiguous, then req2.
    wr_log.delete();
    base = wr_count;
    push(1, 8'hAA, 1'b0); push(1, 8'hBB, 1'b0); push(1, 8'hCC, 1'b1);
    push(2, 8'hDD, 1'b1);
    expect_wr(8'hAA, 2'd1); expect_wr(8'hBB, 2'd1); expect_wr(8'hCC, 2'd1);
    expect_wr(8'hDD, 2'd2);
    wait_writes(base + 4, 40);
    if (wr_log.size() == 4) begin
      check("pkt_gap1", wr_log[1] - wr_log[0], 32'd1);
      check("pkt_gap2", wr_log[2] - wr_log[1], 32'd1);
      check("pkt_switch", wr_log[3] - wr_log[2], 32'd2);
    end else begin
      check("pkt_write_count", wr_log.size(), 32'd4);
    end

    // 3) fifo_full for beats 2..4 of a 4-beat packet from req3.
    base = wr_count;
    push(3, 8'hE1, 1'b0); push(3, 8'hE2, 1'b0);
    push(3, 8'hE3, 1'b0); push(3, 8'hE4, 1'b1);
    expect_wr(8'hE1, 2'd3); expect_wr(8'hE2, 2'd3);
    expect_wr(8'hE3, 2'd3); expect_wr(8'hE4, 2'd3);
    wait_writes(base + 1, 20);
    @(posedge clk); #1;
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      check("full_ready", {28'd0, req_ready}, 32'd0);
      check("full_grant", {28'd0, grant}, 32'h8);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    wait_writes(base + 4, 20);

    // 4) prog_full blocks the packet start.
    @(posedge clk); #1;
    base = wr_count;
    fifo_prog_full = 1'b1;
    push(0, 8'h77, 1'b1);
    expect_wr(8'h77, 2'd0);
    repeat (10) begin
      @(negedge clk);
      check("pfull_grant", {28'd0, grant}, 32'd0);
    end
    @(posedge clk); #1;
    fifo_prog_full = 1'b0;
    @(negedge clk);
    check("pfull_pre_edge", {28'd0, grant}, 32'd0);
    @(negedge clk);
    check("pfull_grant_on", {28'd0, grant}, 32'h1);
    wait_writes(base + 1, 20);

    // 5) Reset after beat 2 of 5; only two beats reach the FIFO.
    @(negedge clk);
    base = wr_count;
    push(1, 8'h01, 1'b0); push(1, 8'h02, 1'b0); push(1, 8'h03, 1'b0);
    push(1, 8'h04, 1'b0); push(1, 8'h05, 1'b1);
    expect_wr(8'h01, 2'd1); expect_wr(8'h02, 2'd1);
    wait_writes(base + 2, 20);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_grant", {28'd0, grant}, 32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    check("arst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("arst_ready", {28'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("arst_grant_id", {30'd0, grant_id}, 32'd0);
    base = wr_count;
    push(3, 8'h33, 1'b1); push(0, 8'h03, 1'b1);
    expect_wr(8'h03, 2'd0); expect_wr(8'h33, 2'd3);
    wait_writes(base + 2, 20);

    // 6) req0 and req2 continuously requesting single-beat packets.
    @(negedge clk);
    base = wr_count;
    push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b1);
    push(2, 8'hC0, 1'b1); push(2, 8'hC1, 1'b1); push(2, 8'hC2, 1'b1);
`ifdef OH_FIFO_ARB_FIXEDPRIO_EN
    expect_wr(8'hA0, 2'd0); expect_wr(8'hA1, 2'd0); expect_wr(8'hA2, 2'd0);
    expect_wr(8'hC0, 2'd2); expect_wr(8'hC1, 2'd2); expect_wr(8'hC2, 2'd2);
`else
    expect_wr(8'hA0, 2'd0); expect_wr(8'hC0, 2'd2); expect_wr(8'hA1, 2'd0);
    expect_wr(8'hC1, 2'd2); expect_wr(8'hA2, 2'd0); expect_wr(8'hC2, 2'd2);
`endif
    wait_writes(base + 6, 40);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", sb.size(), 32'd0);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
